// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types and constants for the flexible counter
package flex_counter_pkg;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

  // Counting down terminates at 1, so the range matches counting up (1..rollover).
  localparam int unsigned DOWN_TERMINAL = 1;

endpackage

// File: rtl/flex_counter_ch.sv
// rtl/flex_counter_ch.sv - one counter channel: next-count logic, count/flag/pulse registers
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         down_i,
  input  logic         sat_i,
  input  logic [W-1:0] rollover_i,
  output logic [W-1:0] count_o,
  output logic         flag_o,
  output logic         pulse_o,
  output logic         wrap_evt_o
);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] DOWN_TRM = W'(DOWN_TERMINAL);

  dir_e         dir;
  mode_e        mode;
  logic [W-1:0] count_q, count_d;
  logic         flag_q, flag_d;
  logic         pulse_q;
  logic         evt;
  logic [W-1:0] terminal;

  assign dir      = dir_e'(down_i);
  assign mode     = mode_e'(sat_i);
  assign terminal = (dir == DIR_DOWN) ? DOWN_TRM : rollover_i;

  always_comb begin
    count_d = count_q;
    evt     = 1'b0;
    if (clear_i || rollover_i == '0) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (dir == DIR_UP) begin
        if (count_q >= rollover_i) begin
          if (mode == MODE_WRAP) begin
            count_d = ONE;
            evt     = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q <= DOWN_TRM) begin
          if (mode == MODE_WRAP) begin
            count_d = rollover_i;
            evt     = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // Flag is computed from the next count so it lines up with count_o.
  assign flag_d = (count_d == terminal) && (rollover_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= evt;
    end
  end

  assign count_o    = count_q;
  assign flag_o     = flag_q;
  assign pulse_o    = pulse_q;
  assign wrap_evt_o = evt;

endmodule

// File: rtl/flex_counter_mc.sv
// rtl/flex_counter_mc.sv - NUM_CH independent or cascaded flexible counters
module flex_counter_mc
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2,
  parameter bit CASCADE      = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH-1:0]              saturate,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              wrap_pulse
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic en_w;
    logic evt_w;

    // Cascaded channels ripple the carry combinationally within one edge.
    if (CASCADE && k > 0) begin : g_casc
      assign en_w = count_enable[k] & g_ch[k-1].evt_w;
    end else begin : g_solo
      assign en_w = count_enable[k];
    end

    flex_counter_ch #(
      .W(NUM_CNT_BITS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear[k]),
      .load_i    (load[k]),
      .load_val_i(load_val[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .en_i      (en_w),
      .down_i    (count_down[k]),
      .sat_i     (saturate[k]),
      .rollover_i(rollover_val[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_o   (count_out[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .flag_o    (rollover_flag[k]),
      .pulse_o   (wrap_pulse[k]),
      .wrap_evt_o(evt_w)
    );
  end

endmodule

// File: tb/tb_flex_counter_mc.sv
// tb/tb_flex_counter_mc.sv - scoreboard bench for flex_counter_mc (independent and cascaded)
module tb_flex_counter_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clear, load, count_enable, count_down, saturate;
  logic [7:0] load_val, rollover_val;
  logic [7:0] cnt_i, cnt_c;
  logic [1:0] flg_i, flg_c, pls_i, pls_c;

  always #5 clk = ~clk;

  flex_counter_mc #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1'b0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .saturate(saturate),
    .rollover_val(rollover_val), .count_out(cnt_i), .rollover_flag(flg_i),
    .wrap_pulse(pls_i)
  );

  flex_counter_mc #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .saturate(saturate),
    .rollover_val(rollover_val), .count_out(cnt_c), .rollover_flag(flg_c),
    .wrap_pulse(pls_c)
  );

  typedef struct {
    string      tag;
    bit         casc;
    logic [7:0] cnt;
    logic [1:0] flg;
    logic [1:0] pls;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the inputs currently driven, clock once, then score.
  task automatic step(input string tag, input bit casc, input logic [7:0] cnt,
                      input logic [1:0] flg, input logic [1:0] pls);
    exp_t e;
    e.tag = tag; e.casc = casc; e.cnt = cnt; e.flg = flg; e.pls = pls;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.casc) begin
      chk({e.tag, ".cnt"}, 32'(cnt_c), 32'(e.cnt));
      chk({e.tag, ".flag"}, 32'(flg_c), 32'(e.flg));
      chk({e.tag, ".pulse"}, 32'(pls_c), 32'(e.pls));
    end else begin
      chk({e.tag, ".cnt"}, 32'(cnt_i), 32'(e.cnt));
      chk({e.tag, ".flag"}, 32'(flg_i), 32'(e.flg));
      chk({e.tag, ".pulse"}, 32'(pls_i), 32'(e.pls));
    end
  endtask

  initial begin
    logic [3:0] up_cnt[7];
    logic       up_flg[7];
    logic       up_pls[7];
    logic [3:0] cc0[7];
    logic [3:0] cc1[7];
    logic [1:0] cf[7];
    logic [1:0] cp[7];

    up_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
    up_flg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    up_pls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cc0    = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};
    cc1    = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    cf     = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
    cp     = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};

    rst = 1'b1; clear = '0; load = '0; load_val = '0; count_enable = '0;
    count_down = '0; saturate = '0; rollover_val = '0;
    step("reset", 1'b0, 8'h00, 2'b00, 2'b00);

    // Ch0 up/wrap at 5; ch1 idle with zero rollover.
    rst = 1'b0; rollover_val = 8'h05; count_enable = 2'b01;
    for (int i = 0; i < 7; i++)
      step($sformatf("wrap_up%0d", i), 1'b0, {4'd0, up_cnt[i]}, {1'b0, up_flg[i]},
           {1'b0, up_pls[i]});

    // Load 3, then count down in saturate mode.
    count_enable = 2'b00; load = 2'b01; load_val = 8'h03;
    count_down = 2'b01; saturate = 2'b01;
    step("dsat_load", 1'b0, 8'h03, 2'b00, 2'b00);
    load = 2'b00; count_enable = 2'b01;
    step("dsat0", 1'b0, 8'h02, 2'b00, 2'b00);
    step("dsat1", 1'b0, 8'h01, 2'b01, 2'b00);
    step("dsat2", 1'b0, 8'h01, 2'b01, 2'b00);
    step("dsat3", 1'b0, 8'h01, 2'b01, 2'b00);

    // Priority: clear beats load and enable; oversize load kept; then wrap from above.
    count_down = 2'b00; saturate = 2'b00;
    clear = 2'b01; load = 2'b01; load_val = 8'h07; count_enable = 2'b01;
    step("prio_clear", 1'b0, 8'h00, 2'b00, 2'b00);
    clear = 2'b00; count_enable = 2'b00;
    step("prio_load", 1'b0, 8'h07, 2'b00, 2'b00);
    load = 2'b00; count_enable = 2'b01;
    step("prio_wrap", 1'b0, 8'h01, 2'b00, 2'b01);

    // Zero rollover disables the channel over load and enable.
    rollover_val = 8'h00; load = 2'b01; load_val = 8'h02;
    step("zero0", 1'b0, 8'h00, 2'b00, 2'b00);
    step("zero1", 1'b0, 8'h00, 2'b00, 2'b00);
    rollover_val = 8'h03; load = 2'b00;
    step("zero_r1", 1'b0, 8'h01, 2'b00, 2'b00);
    step("zero_r2", 1'b0, 8'h02, 2'b00, 2'b00);
    step("zero_r3", 1'b0, 8'h03, 2'b01, 2'b00);

    // Reset while counting at 4.
    load = 2'b01; load_val = 8'h03; rollover_val = 8'h05; count_enable = 2'b00;
    step("rst_pre", 1'b0, 8'h03, 2'b00, 2'b00);
    load = 2'b00; count_enable = 2'b01;
    step("rst_at4", 1'b0, 8'h04, 2'b00, 2'b00);
    rst = 1'b1;
    step("rst_mid", 1'b0, 8'h00, 2'b00, 2'b00);
    rst = 1'b0;
    step("rst_resume", 1'b0, 8'h01, 2'b00, 2'b00);

    // Cascade: ch0 rollover 3, ch1 rollover 2, both enabled.
    rst = 1'b1; count_enable = 2'b00; rollover_val = 8'h23;
    step("casc_rst", 1'b1, 8'h00, 2'b00, 2'b00);
    rst = 1'b0; count_enable = 2'b11;
    for (int i = 0; i < 7; i++)
      step($sformatf("casc%0d", i), 1'b1, {cc1[i], cc0[i]}, cf[i], cp[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
